vga_frame_reader: RTL and testbench

- Pixel-fetch stage directly downstream of the 640x480 VGA sync generator.
- Consumes its pixel_x/pixel_y/video_on/p_tick/hsync/vsync, places an IMG_W x IMG_H grayscale image window at (X0,Y0), reads 8-bit pixels from a synchronous frame memory, and expands each pixel to 12-bit RGB.
- Delays hsync/vsync by the fetch latency so colour and sync stay aligned at the DAC pins.

---
 rtl/vga_frame_reader.sv | 152 +++++++++++++++
 tb/tb_vga_frame_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: pixel-fetch stage behind a 640x480 VGA sync generator.
// Places an IMG_W x IMG_H grayscale window at (X0,Y0), reads 8-bit pixels
// from a synchronous frame memory, expands them to 12-bit RGB, and delays
// hsync/vsync by the same two p_tick stages so colour and sync stay aligned.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   p_tick                  pixel enable (one clk in two)
//   video_on, hsync_in,
//   vsync_in, pixel_x/y     raster state from the sync generator
//   mem_addr, mem_rd_en     frame memory read port (rd_en is combinational)
//   mem_data                pixel from memory, valid one clk after rd_en
//   rgb, hsync_out,
//   vsync_out               colour and sync, 2 p_tick periods behind input
//   frame_start             one-clk pulse after the p_tick at pixel (0,0)
//
// Optional feature macro: VGA_FRAME_BORDER_EN draws a one-pixel 12'hFFF ring
// just outside the window (requires X0>=1 and Y0>=1).

module vga_frame_reader #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X0       = 192,
  parameter int unsigned Y0       = 112,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [7:0]        mem_data,
  output logic [11:0]       rgb,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_start
);

  // One extra bit so the counter can hold IMG_W*IMG_H after the last read.
  localparam int unsigned CNT_W = ADDR_W + 1;

  // Window bounds in 11 bits so X0+IMG_W cannot overflow.
  localparam logic [10:0] X_LO = 11'(X0);
  localparam logic [10:0] X_HI = 11'(X0 + IMG_W);
  localparam logic [10:0] Y_LO = 11'(Y0);
  localparam logic [10:0] Y_HI = 11'(Y0 + IMG_H);

  logic [10:0]      w_px;
  logic [10:0]      w_py;
  logic             w_in_win;
  logic             w_origin;
  logic             w_unused_lo;

  logic [CNT_W-1:0] r_addr;
  logic             r_in_win_d1;
  logic             r_video_on_d1;
  logic             r_hsync_d1;
  logic             r_vsync_d1;
  logic [11:0]      r_rgb;
  logic             r_hsync_out;
  logic             r_vsync_out;
  logic             r_frame_start;

  assign w_px     = {1'b0, pixel_x};
  assign w_py     = {1'b0, pixel_y};
  assign w_in_win = video_on && (w_px >= X_LO) && (w_px < X_HI)
                             && (w_py >= Y_LO) && (w_py < Y_HI);
  assign w_origin = (pixel_x == 10'd0) && (pixel_y == 10'd0);

  // Only the top nibble of each gray sample reaches the DAC.
  assign w_unused_lo = &{1'b0, mem_data[3:0]};

`ifdef VGA_FRAME_BORDER_EN
  // Ring one pixel outside the window on every side.
  localparam logic [10:0] BX_L = 11'(X0 - 1);
  localparam logic [10:0] BX_R = 11'(X0 + IMG_W);
  localparam logic [10:0] BY_T = 11'(Y0 - 1);
  localparam logic [10:0] BY_B = 11'(Y0 + IMG_H);

  logic w_border;
  logic r_border_d1;

  assign w_border = video_on &&
    ((((w_px == BX_L) || (w_px == BX_R)) && (w_py >= BY_T) && (w_py <= BY_B)) ||
     (((w_py == BY_T) || (w_py == BY_B)) && (w_px >= BX_L) && (w_px <= BX_R)));
`endif

  assign mem_rd_en   = p_tick && w_in_win;
  assign mem_addr    = r_addr[ADDR_W-1:0];
  assign rgb         = r_rgb;
  assign hsync_out   = r_hsync_out;
  assign vsync_out   = r_vsync_out;
  assign frame_start = r_frame_start;

  // Address counter, frame pulse and the two p_tick pipeline stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_in_win_d1   <= 1'b0;
      r_video_on_d1 <= 1'b0;
      r_hsync_d1    <= 1'b0;
      r_vsync_d1    <= 1'b0;
      r_rgb         <= 12'h000;
      r_hsync_out   <= 1'b0;
      r_vsync_out   <= 1'b0;
      r_frame_start <= 1'b0;
`ifdef VGA_FRAME_BORDER_EN
      r_border_d1   <= 1'b0;
`endif
    end else begin
      r_frame_start <= p_tick && w_origin;
      if (p_tick) begin
        // Frame restart wins over increment; no wrap within a frame.
        if (w_origin) begin
          r_addr <= '0;
        end else if (w_in_win) begin
          r_addr <= r_addr + CNT_W'(1);
        end

        r_in_win_d1   <= w_in_win;
        r_video_on_d1 <= video_on;
        r_hsync_d1    <= hsync_in;
        r_vsync_d1    <= vsync_in;
`ifdef VGA_FRAME_BORDER_EN
        r_border_d1   <= w_border;
`endif

        r_hsync_out <= r_hsync_d1;
        r_vsync_out <= r_vsync_d1;
        // mem_data has been held by the memory since the previous p_tick read.
        if (!r_video_on_d1) begin
          r_rgb <= 12'h000;
        end else if (r_in_win_d1) begin
          r_rgb <= {mem_data[7:4], mem_data[7:4], mem_data[7:4]};
`ifdef VGA_FRAME_BORDER_EN
        end else if (r_border_d1) begin
          r_rgb <= 12'hFFF;
`endif
        end else begin
          r_rgb <= BG_COLOR;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a shrunken raster (26x13 pixels, 8x4 window
// at (5,3)) so several whole frames fit in a short run. A spec-level model
// predicts every output from the raster coordinates; literal expectations at
// chosen pixels pin the model.

module tb_vga_frame_reader;

  localparam int unsigned IMG_W  = 8;
  localparam int unsigned IMG_H  = 4;
  localparam int unsigned X0     = 5;
  localparam int unsigned Y0     = 3;
  localparam int unsigned ADDR_W = 5;
  localparam logic [11:0] BG     = 12'h123;

  localparam int H_VIS = 20, H_TOT = 26, HS_B = 21, HS_E = 24;
  localparam int V_VIS = 10, V_TOT = 13, VS_B = 11, VS_E = 13;

`ifdef VGA_FRAME_BORDER_EN
  localparam logic [11:0] RING = 12'hFFF;
`else
  localparam logic [11:0] RING = 12'h123;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              p_tick = 1'b0;
  logic              video_on = 1'b0;
  logic              hsync_in = 1'b0;
  logic              vsync_in = 1'b0;
  logic [9:0]        pixel_x = '0;
  logic [9:0]        pixel_y = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_data = 8'h00;
  logic [11:0]       rgb;
  logic              hsync_out;
  logic              vsync_out;
  logic              frame_start;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X0(X0), .Y0(Y0),
    .ADDR_W(ADDR_W), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick), .video_on(video_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_data(mem_data),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_start(frame_start)
  );

  function automatic logic [7:0] mem_fn(input int a);
    int t;
    t = a * 29 + 165;
    return t[7:0];
  endfunction

  // Synchronous memory: data one clk after the read, held otherwise.
  always @(posedge clk) if (mem_rd_en) mem_data <= mem_fn(int'(mem_addr));

  function automatic logic in_win_f(input int x, input int y, input logic vo);
    return vo && x >= int'(X0) && x < int'(X0 + IMG_W) &&
           y >= int'(Y0) && y < int'(Y0 + IMG_H);
  endfunction

  function automatic logic ring_f(input int x, input int y, input logic vo);
`ifdef VGA_FRAME_BORDER_EN
    int xl, xr, yt, yb;
    xl = int'(X0) - 1; xr = int'(X0 + IMG_W);
    yt = int'(Y0) - 1; yb = int'(Y0 + IMG_H);
    return vo && (((x == xl || x == xr) && y >= yt && y <= yb) ||
                  ((y == yt || y == yb) && x >= xl && x <= xr));
`else
    return 1'b0 & vo & (x == y);
`endif
  endfunction

  function automatic logic [11:0] rgb_f(input int x, input int y, input logic vo);
    logic [7:0] g;
    if (!vo) return 12'h000;
    if (in_win_f(x, y, vo)) begin
      g = mem_fn((y - int'(Y0)) * int'(IMG_W) + (x - int'(X0)));
      return {g[7:4], g[7:4], g[7:4]};
    end
    if (ring_f(x, y, vo)) return 12'hFFF;
    return BG;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        ok;
    int          x;
    int          y;
    int          first;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n = 0;
  logic prev_rst_n = 1'b1, prev_org = 1'b0, prev_pt = 1'b0;
  logic prev_hsi = 1'b0, prev_hso = 1'b0, prev_vsi = 1'b0, prev_vso = 1'b0;
  logic frame_ok = 1'b0, cnt_valid = 1'b0, w;
  int   reads = 0, last_fs = -1;
  int   hsi_r = -1, hso_r = -1, vsi_r = -1, vso_r = -1;
  int   cx, cy;

  // Compare process: all outputs against the model on every sample.
  always @(negedge clk) begin
    n = n + 1;
    cx = int'(pixel_x);
    cy = int'(pixel_y);
    if (rst_n) begin
      if (!prev_rst_n) begin
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_hsync_out", int'(hsync_out), 0);
        chk("rst_vsync_out", int'(vsync_out), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_frame_start", int'(frame_start), 0);
      end else begin
        chk("frame_start", int'(frame_start), int'(prev_org));
        if (q.size() >= 2) begin
          e = q[q.size() - 2];
          chk("hsync_out", int'(hsync_out), int'(e.hs));
          chk("vsync_out", int'(vsync_out), int'(e.vs));
          if (e.ok) chk("rgb", int'(rgb), int'(e.rgb));
          if (prev_pt && e.ok) begin
            if (e.x == 5 && e.y == 3) begin
              chk("rgb@5,3", int'(rgb), 'hAAA);
              chk("lat@5,3", n - e.first, 4);
            end
            if (e.x == 6 && e.y == 3)  chk("rgb@6,3", int'(rgb), 'hCCC);
            if (e.x == 12 && e.y == 6) chk("rgb@12,6", int'(rgb), 'h222);
            if (e.x == 1 && e.y == 1)  chk("rgb@1,1", int'(rgb), 'h123);
            if (e.x == 22 && e.y == 1) chk("rgb@22,1", int'(rgb), 'h000);
            if (e.x == 3 && e.y == 3)  chk("rgb@3,3", int'(rgb), 'h123);
            if (e.x == 4 && e.y == 3)  chk("rgb@4,3", int'(rgb), int'(RING));
            if (e.x == 13 && e.y == 7) chk("rgb@13,7", int'(rgb), int'(RING));
          end
        end
        if (frame_start) begin
          if (last_fs >= 0) chk("frame_period", n - last_fs, 676);
          last_fs = n;
        end
        if (hsync_out && !prev_hso) begin
          if (hsi_r >= 0) chk("hs_lag", n - hsi_r, 4);
          hso_r = n;
        end
        if (!hsync_out && prev_hso && hso_r >= 0) chk("hs_width", n - hso_r, 6);
        if (vsync_out && !prev_vso) begin
          if (vsi_r >= 0) chk("vs_lag", n - vsi_r, 4);
          vso_r = n;
        end
        if (!vsync_out && prev_vso && vso_r >= 0) chk("vs_width", n - vso_r, 104);
      end
      if (hsync_in && !prev_hsi) hsi_r = n;
      if (vsync_in && !prev_vsi) vsi_r = n;

      w = in_win_f(cx, cy, video_on);
      chk("mem_rd_en", int'(mem_rd_en), int'(p_tick && w));
      if (mem_rd_en) reads++;
      if (p_tick && cx == 0 && cy == 0) begin
        if (cnt_valid) chk("reads_per_frame", reads, 32);
        reads = 0;
        cnt_valid = 1'b1;
        frame_ok = 1'b1;
      end
      if (p_tick && w && frame_ok) begin
        chk("mem_addr", int'(mem_addr),
            (cy - int'(Y0)) * int'(IMG_W) + (cx - int'(X0)));
        if (cx == 5 && cy == 3)  chk("addr@5,3", int'(mem_addr), 0);
        if (cx == 12 && cy == 3) chk("addr@12,3", int'(mem_addr), 7);
        if (cx == 5 && cy == 4)  chk("addr@5,4", int'(mem_addr), 8);
        if (cx == 12 && cy == 6) chk("addr@12,6", int'(mem_addr), 31);
      end
      if (p_tick) begin
        q.push_back('{rgb_f(cx, cy, video_on), hsync_in, vsync_in, frame_ok,
                      cx, cy, n - 1});
        if (q.size() > 3) void'(q.pop_front());
      end
    end else begin
      q.delete();
      frame_ok = 1'b0;
      cnt_valid = 1'b0;
      last_fs = -1;
      hsi_r = -1; hso_r = -1; vsi_r = -1; vso_r = -1;
    end
    prev_rst_n = rst_n;
    prev_org   = p_tick && cx == 0 && cy == 0;
    prev_pt    = p_tick;
    prev_hsi   = hsync_in;
    prev_hso   = hsync_out;
    prev_vsi   = vsync_in;
    prev_vso   = vsync_out;
  end

  // One pixel = two clk, p_tick in the second, as the sync generator does.
  task automatic drive_pixel(input int x, input int y, input logic rst_v);
    @(posedge clk); #1;
    rst_n    = rst_v;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = (x < H_VIS) && (y < V_VIS);
    hsync_in = (x >= HS_B) && (x < HS_E);
    vsync_in = (y >= VS_B) && (y < VS_E);
    p_tick   = 1'b0;
    @(posedge clk); #1;
    p_tick   = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      p_tick   = 1'($urandom_range(0, 1));
      video_on = 1'($urandom_range(0, 1));
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      pixel_x  = 10'($urandom_range(0, 799));
      pixel_y  = 10'($urandom_range(0, 524));
    end
    // Four frames; frame 2 takes a reset in the middle of the window.
    for (int f = 0; f < 4; f++)
      for (int y = 0; y < V_TOT; y++)
        for (int x = 0; x < H_TOT; x++)
          drive_pixel(x, y, !(f == 1 && y == 4 && (x == 8 || x == 9)));
    for (int x = 0; x < 4; x++) drive_pixel(x, 0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
